// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the IF/ID pipeline boundary.
//   PIPE_DW        payload field width used by if_id_t
//   NOP_INSTR_DEF  default bubble instruction (addi x0, x0, 0)
//   if_id_t        fetch->decode payload {instr, pc, pc_plus}
//   skid_state_e   occupancy of the IF/ID skid register
//   nop_payload()  bubble payload: NOP instruction, zero PC fields
package pipe_pkg;

  localparam int PIPE_DW = 32;
  localparam logic [PIPE_DW-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [PIPE_DW-1:0] instr;
    logic [PIPE_DW-1:0] pc;
    logic [PIPE_DW-1:0] pc_plus;
  } if_id_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic if_id_t nop_payload(input logic [PIPE_DW-1:0] nop);
    if_id_t p;
    p.instr   = nop;
    p.pc      = '0;
    p.pc_plus = '0;
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk    clock, counts on rising edge
//   rst    asynchronous active-low clear
//   inc    count this cycle
//   count  current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with a one-entry skid buffer, so
// ready_f can be a pure flop output (no combinational path from ready_d).
//   clk, rst                   clock, asynchronous active-low reset
//   flush                      drop everything held, present a NOP bubble
//   valid_f/ready_f            fetch-side handshake (ready_f registered)
//   InstrF, PCF, PC_PlusF      fetch payload
//   valid_d/ready_d            decode-side handshake (ready_d low = stall)
//   InstrD, PCD, PC_PlusD      decode payload, straight from flops
//   state_dbg                  current skid_state_e, for observation
//   stall_cnt, flush_cnt       only when IF_ID_PERF_CNT_EN is defined
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; a producer holding valid keeps its payload stable until it transfers.
// DATA_WIDTH must equal pipe_pkg::PIPE_DW since the payload uses if_id_t.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = PIPE_DW,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_f,
  output logic                  ready_f,
  input  logic [DATA_WIDTH-1:0] InstrF,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0] PC_PlusF,
  output logic                  valid_d,
  input  logic                  ready_d,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PC_PlusD,
  output logic [1:0]            state_dbg
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  skid_state_e state_q, state_d;
  if_id_t      out_q, out_d;
  if_id_t      skid_q, skid_d;
  logic        ready_f_q, ready_f_d;
  logic        valid_d_q, valid_d_d;
  if_id_t      fetch_pl;
  logic        accept;
  logic        drain;

  assign fetch_pl.instr   = InstrF;
  assign fetch_pl.pc      = PCF;
  assign fetch_pl.pc_plus = PC_PlusF;

  assign accept = valid_f & ready_f_q;
  assign drain  = valid_d_q & ready_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      // Redirect wins over any accept/drain in the same cycle.
      state_d = SKID_EMPTY;
      out_d   = nop_payload(NOP_INSTR);
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            out_d   = fetch_pl;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            out_d = fetch_pl;
          end else if (accept) begin
            // Decode stalled while fetch already saw ready: park in skid.
            skid_d  = fetch_pl;
            state_d = SKID_TWO;
          end else if (drain) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          // ready_f is low here, so no accept can occur.
          if (drain) begin
            out_d   = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    // Handshake flags follow the next state so they are plain flop outputs.
    ready_f_d = (state_d != SKID_TWO);
    valid_d_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SKID_EMPTY;
      out_q     <= nop_payload(NOP_INSTR);
      skid_q    <= '0;
      ready_f_q <= 1'b0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      ready_f_q <= ready_f_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign ready_f   = ready_f_q;
  assign valid_d   = valid_d_q;
  assign InstrD    = out_q.instr;
  assign PCD       = out_q.pc;
  assign PC_PlusD  = out_q.pc_plus;
  assign state_dbg = state_q;

`ifdef IF_ID_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_d_q & ~ready_d),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );
`endif

endmodule
